// File: rtl/store_buffer_pkg.sv
// Shared types and limits for the committed-store buffer.
// Entry fields are sized for the widest supported configuration; narrower builds zero-extend.
package store_buffer_pkg;

   localparam int SB_MIN_DEPTH  = 2;
   localparam int SB_MAX_DEPTH  = 16;
   localparam int SB_MAX_ADDR_W = 64;
   localparam int SB_MAX_DATA_W = 64;
   localparam int SB_MAX_MASK_W = SB_MAX_DATA_W / 8;

   typedef struct packed {
      logic [SB_MAX_ADDR_W-1:0] addr;
      logic [SB_MAX_DATA_W-1:0] data;
      logic [SB_MAX_MASK_W-1:0] mask;
   } sb_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FENCE = 1'b1
   } sb_state_e;

   function automatic bit sb_depth_legal(input int depth);
      return (depth >= SB_MIN_DEPTH) && (depth <= SB_MAX_DEPTH) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-byte-lane store-to-load forwarding: the youngest matching entry covering a lane supplies it.
// Inputs are age ordered, index 0 oldest; only built into store_buffer when STORE_BUFFER_FWD_EN is defined.
module sb_fwd_merge #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic [DEPTH-1:0]    match_i,
   input  logic [DATA_W-1:0]   data_i [DEPTH],
   input  logic [DATA_W/8-1:0] mask_i [DEPTH],
   output logic [DATA_W-1:0]   data_o,
   output logic [DATA_W/8-1:0] mask_o,
   output logic                conflict_o
);

   localparam int MASK_W = DATA_W / 8;

   logic [MASK_W-1:0] covered;

   genvar gi;
   generate
      for (gi = 0; gi < MASK_W; gi++) begin : g_lane
         logic [7:0] lane_data;
         logic       lane_hit;

         // Later (younger) entries overwrite earlier picks as the scan advances.
         always_comb begin
            lane_data = '0;
            lane_hit  = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
               if (match_i[a] && mask_i[a][gi]) begin
                  lane_hit  = 1'b1;
                  lane_data = data_i[a][gi*8 +: 8];
               end
            end
         end

         assign data_o[gi*8 +: 8] = lane_data;
         assign mask_o[gi]        = lane_hit;
      end
   endgenerate

   always_comb begin
      covered = '0;
      for (int a = 0; a < DEPTH; a++) begin
         if (match_i[a]) begin
            covered = covered | mask_i[a];
         end
      end
   end

   assign conflict_o = |(covered & ~mask_o);

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: FIFO of stores draining to data memory, with fence and load lookup.
// Define STORE_BUFFER_FWD_EN to forward matching bytes to loads instead of flagging a conflict.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enq_valid_i,
   output logic                    enq_ready_o,
   input  logic [ADDR_W-1:0]       enq_addr_i,
   input  logic [DATA_W-1:0]       enq_data_i,
   input  logic [DATA_W/8-1:0]     enq_mask_i,
   output logic [ADDR_W-1:0]       DMemWAddr_o,
   output logic [DATA_W-1:0]       DMemWData_o,
   output logic [DATA_W/8-1:0]     DMemWMask_o,
   input  logic                    DMemWReady_i,
   input  logic [ADDR_W-1:0]       ld_addr_i,
   output logic [DATA_W-1:0]       ld_data_o,
   output logic [DATA_W/8-1:0]     ld_mask_o,
   output logic                    ld_conflict_o,
   input  logic                    fence_i,
   output logic                    fence_done_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int MASK_W     = DATA_W / 8;
   localparam int PTR_W      = $clog2(DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int LANE_SHIFT = $clog2(MASK_W);

   sb_entry_t        entries_q [DEPTH];
   sb_entry_t        enq_entry_d;
   sb_entry_t        head_entry;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   sb_state_e        state_q, state_d;
   logic             fence_done_q, fence_done_d;
   logic             enq_fire;
   logic             deq_fire;
   logic             unused_head;

   assign enq_ready_o = reset_i && (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
   assign enq_fire    = enq_valid_i && enq_ready_o;
   assign deq_fire    = DMemWReady_i && (count_q != '0);

   always_comb begin
      enq_entry_d      = '0;
      enq_entry_d.addr = SB_MAX_ADDR_W'(enq_addr_i);
      enq_entry_d.data = SB_MAX_DATA_W'(enq_data_i);
      enq_entry_d.mask = SB_MAX_MASK_W'(enq_mask_i);
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq_fire) begin
         head_d = head_q + PTR_W'(1);
      end
      if (enq_fire) begin
         tail_d = tail_q + PTR_W'(1);
      end
      if (enq_fire && !deq_fire) begin
         count_d = count_q + CNT_W'(1);
      end else if (!enq_fire && deq_fire) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // A fence completes on the edge where the buffer becomes (or already is) empty.
   always_comb begin
      state_d      = state_q;
      fence_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (fence_i) begin
               if (count_d == '0) begin
                  fence_done_d = 1'b1;
               end else begin
                  state_d = FENCE;
               end
            end
         end
         FENCE: begin
            if (count_d == '0) begin
               state_d      = RUN;
               fence_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         state_q      <= RUN;
         fence_done_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         state_q      <= state_d;
         fence_done_q <= fence_done_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         entries_q[tail_q] <= enq_entry_d;
      end
   end

   assign head_entry  = entries_q[head_q];
   assign unused_head = ^head_entry;

   always_comb begin
      DMemWAddr_o = '0;
      DMemWData_o = '0;
      DMemWMask_o = '0;
      if (count_q != '0) begin
         DMemWAddr_o = head_entry.addr[ADDR_W-1:0];
         DMemWData_o = head_entry.data[DATA_W-1:0];
         DMemWMask_o = head_entry.mask[MASK_W-1:0];
      end
   end

   assign fence_done_o = fence_done_q;
   assign empty_o      = (count_q == '0);
   assign count_o      = count_q;

   // Lookup sees only registered entries: the one retiring this cycle counts, the one arriving does not.
   logic [SB_MAX_ADDR_W-1:0] ld_word;
   logic [PTR_W-1:0]         ord_slot [DEPTH];
   logic [DEPTH-1:0]         ord_match;

   assign ld_word = SB_MAX_ADDR_W'(ld_addr_i) >> LANE_SHIFT;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_age
         assign ord_slot[gi]  = head_q + PTR_W'(gi);
         assign ord_match[gi] = (CNT_W'(gi) < count_q) &&
                                ((entries_q[ord_slot[gi]].addr >> LANE_SHIFT) == ld_word);
      end
   endgenerate

`ifdef STORE_BUFFER_FWD_EN
   logic [DATA_W-1:0] ord_data [DEPTH];
   logic [MASK_W-1:0] ord_mask [DEPTH];

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_fwd_src
         assign ord_data[gi] = entries_q[ord_slot[gi]].data[DATA_W-1:0];
         assign ord_mask[gi] = entries_q[ord_slot[gi]].mask[MASK_W-1:0];
      end
   endgenerate

   sb_fwd_merge #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fwd_merge (
      .match_i    (ord_match),
      .data_i     (ord_data),
      .mask_i     (ord_mask),
      .data_o     (ld_data_o),
      .mask_o     (ld_mask_o),
      .conflict_o (ld_conflict_o)
   );
`else
   assign ld_data_o     = '0;
   assign ld_mask_o     = '0;
   assign ld_conflict_o = |ord_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue-based model.
// Expectations follow the STORE_BUFFER_FWD_EN setting of the build.
module tb_store_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = DATA_W / 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enq_valid, enq_ready;
   logic [ADDR_W-1:0] enq_addr;
   logic [DATA_W-1:0] enq_data;
   logic [MASK_W-1:0] enq_mask;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] wr_mask;
   logic              wr_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [MASK_W-1:0] ld_mask;
   logic              ld_conflict;
   logic              fence, fence_done, empty;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i         (clk),
      .reset_i       (reset_n),
      .enq_valid_i   (enq_valid),
      .enq_ready_o   (enq_ready),
      .enq_addr_i    (enq_addr),
      .enq_data_i    (enq_data),
      .enq_mask_i    (enq_mask),
      .DMemWAddr_o   (wr_addr),
      .DMemWData_o   (wr_data),
      .DMemWMask_o   (wr_mask),
      .DMemWReady_i  (wr_ready),
      .ld_addr_i     (ld_addr),
      .ld_data_o     (ld_data),
      .ld_mask_o     (ld_mask),
      .ld_conflict_o (ld_conflict),
      .fence_i       (fence),
      .fence_done_o  (fence_done),
      .empty_o       (empty),
      .count_o       (count)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } st_t;

   st_t mq[$];
   bit  m_fence;
   bit  m_done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return (a / MASK_W) == (b / MASK_W);
   endfunction

   task automatic check_model();
      bit                exp_ready;
      bit                exp_conf;
      logic [MASK_W-1:0] exp_lmask;
      logic [DATA_W-1:0] exp_ldata;
      exp_ready = reset_n && (mq.size() < DEPTH) && !m_fence;
      check("m_ready", 64'(enq_ready), 64'(exp_ready));
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_empty", 64'(empty), 64'(mq.size() == 0));
      check("m_fence_done", 64'(fence_done), 64'(m_done));
      if (mq.size() == 0) begin
         check("m_wr_mask", 64'(wr_mask), 64'(0));
         check("m_wr_addr", 64'(wr_addr), 64'(0));
      end else begin
         check("m_wr_addr", 64'(wr_addr), 64'(mq[0].addr));
         check("m_wr_data", 64'(wr_data), 64'(mq[0].data));
         check("m_wr_mask", 64'(wr_mask), 64'(mq[0].mask));
      end
      exp_conf  = 1'b0;
      exp_lmask = '0;
      exp_ldata = '0;
`ifdef STORE_BUFFER_FWD_EN
      for (int lane = 0; lane < MASK_W; lane++) begin
         for (int k = mq.size() - 1; k >= 0; k--) begin
            if (same_word(mq[k].addr, ld_addr) && mq[k].mask[lane]) begin
               exp_lmask[lane]         = 1'b1;
               exp_ldata[lane*8 +: 8]  = mq[k].data[lane*8 +: 8];
               break;
            end
         end
      end
      foreach (mq[k]) begin
         if (same_word(mq[k].addr, ld_addr) && ((mq[k].mask & ~exp_lmask) != '0)) exp_conf = 1'b1;
      end
`else
      foreach (mq[k]) begin
         if (same_word(mq[k].addr, ld_addr)) exp_conf = 1'b1;
      end
`endif
      check("m_ld_conflict", 64'(ld_conflict), 64'(exp_conf));
      check("m_ld_mask", 64'(ld_mask), 64'(exp_lmask));
      check("m_ld_data", 64'(ld_data), 64'(exp_ldata));
   endtask

   task automatic model_update();
      bit  do_enq, do_deq;
      st_t e;
      if (!reset_n) begin
         if (mq.size() != 0) $display("[TB] reset discards %0d entries", mq.size());
         mq.delete();
         m_fence = 1'b0;
         m_done  = 1'b0;
         return;
      end
      do_enq = enq_valid && (mq.size() < DEPTH) && !m_fence;
      do_deq = wr_ready && (mq.size() > 0);
      if (do_deq) begin
         e = mq.pop_front();
         $display("[TB] retire addr=%08h data=%08h mask=%h", e.addr, e.data, e.mask);
      end
      if (do_enq) begin
         e.addr = enq_addr;
         e.data = enq_data;
         e.mask = enq_mask;
         mq.push_back(e);
         $display("[TB] enqueue addr=%08h data=%08h mask=%h", e.addr, e.data, e.mask);
      end
      m_done = 1'b0;
      if (!m_fence) begin
         if (fence) begin
            if (mq.size() == 0) m_done = 1'b1;
            else m_fence = 1'b1;
         end
      end else if (mq.size() == 0) begin
         m_fence = 1'b0;
         m_done  = 1'b1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_enq(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
      enq_valid = v;
      enq_addr  = a;
      enq_data  = d;
      enq_mask  = m;
   endtask

   initial begin
      int pulses, done_at, count_at_done, ready_hi;
      reset_n   = 1'b0;
      enq_valid = 1'b0;
      enq_addr  = '0;
      enq_data  = '0;
      enq_mask  = '0;
      wr_ready  = 1'b0;
      ld_addr   = '0;
      fence     = 1'b0;
      m_fence   = 1'b0;
      m_done    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      check("rst_count", 64'(count), 64'(0));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_ready", 64'(enq_ready), 64'(0));
      check("rst_fence_done", 64'(fence_done), 64'(0));
      check("rst_wr_mask", 64'(wr_mask), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check("rst_wr_data", 64'(wr_data), 64'(0));
      check("rst_ld_mask", 64'(ld_mask), 64'(0));
      check("rst_ld_data", 64'(ld_data), 64'(0));
      step();
      reset_n = 1'b1;
      #1;
      check("ready_after_rst", 64'(enq_ready), 64'(1));

      // Single enqueue appears on the drain port the next cycle.
      set_enq(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      step();
      enq_valid = 1'b0;
      check("first_wr_addr", 64'(wr_addr), 64'h100);
      check("first_wr_data", 64'(wr_data), 64'hDEADBEEF);
      check("first_wr_mask", 64'(wr_mask), 64'hF);
      check("first_count", 64'(count), 64'(1));
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      check("first_drained", 64'(count), 64'(0));

      // Fill to full, refuse a fifth, then drain with concurrent enqueue.
      for (int i = 0; i < 5; i++) begin
         set_enq(1'b1, 32'h1000 + 32'(i * 4), 32'($urandom), 4'hF);
         step();
      end
      check("full_ready", 64'(enq_ready), 64'(0));
      check("full_count", 64'(count), 64'(4));
      wr_ready = 1'b1;
      step();
      check("full_retire_only", 64'(count), 64'(3));
      step();
      check("concurrent_count", 64'(count), 64'(3));
      enq_valid = 1'b0;
      repeat (4) step();
      check("full_drained", 64'(count), 64'(0));

      // Lookup with two overlapping stores to one word.
      wr_ready = 1'b0;
      set_enq(1'b1, 32'h200, 32'h11223344, 4'hF);
      step();
      set_enq(1'b1, 32'h200, 32'h000000AA, 4'h1);
      step();
      enq_valid = 1'b0;
      ld_addr   = 32'h200;
      #1;
`ifdef STORE_BUFFER_FWD_EN
      check("fwd_data", 64'(ld_data), 64'h112233AA);
      check("fwd_mask", 64'(ld_mask), 64'hF);
      check("fwd_conflict", 64'(ld_conflict), 64'(0));
`else
      check("nofwd_conflict", 64'(ld_conflict), 64'(1));
      check("nofwd_mask", 64'(ld_mask), 64'(0));
      check("nofwd_data", 64'(ld_data), 64'(0));
`endif
      ld_addr = 32'h204;
      #1;
      check("other_word_conflict", 64'(ld_conflict), 64'(0));
      check("other_word_mask", 64'(ld_mask), 64'(0));
      ld_addr = 32'h300;
      set_enq(1'b1, 32'h300, 32'h55, 4'hF);
      #1;
      check("enq_excluded_conflict", 64'(ld_conflict), 64'(0));
      check("enq_excluded_mask", 64'(ld_mask), 64'(0));
      step();
      enq_valid = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
      check("enq_visible_mask", 64'(ld_mask), 64'hF);
`else
      check("enq_visible_conflict", 64'(ld_conflict), 64'(1));
`endif
      ld_addr  = 32'h200;
      wr_ready = 1'b1;
      step();
      repeat (3) step();
      check("lookup_drained", 64'(count), 64'(0));

      // Fence with three pending stores.
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_enq(1'b1, 32'h400 + 32'(i * 4), 32'($urandom), 4'hF);
         step();
      end
      enq_valid = 1'b0;
      fence     = 1'b1;
      wr_ready  = 1'b1;
      step();
      fence         = 1'b0;
      pulses        = 0;
      done_at       = -1;
      count_at_done = -1;
      ready_hi      = 0;
      for (int c = 0; c < 6; c++) begin
         if (fence_done) begin
            pulses++;
            done_at       = c;
            count_at_done = int'(count);
         end
         if (c < 2 && enq_ready) ready_hi++;
         step();
      end
      check("fence_pulses", 64'(pulses), 64'(1));
      check("fence_done_at", 64'(done_at), 64'(2));
      check("fence_done_count", 64'(count_at_done), 64'(0));
      check("fence_ready_low", 64'(ready_hi), 64'(0));
      fence = 1'b1;
      step();
      fence = 1'b0;
      check("fence_empty_pulse", 64'(fence_done), 64'(1));
      step();
      check("fence_empty_single", 64'(fence_done), 64'(0));

      // Reset while fencing with two entries.
      wr_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_enq(1'b1, 32'h500 + 32'(i * 4), 32'($urandom), 4'h3);
         step();
      end
      enq_valid = 1'b0;
      fence     = 1'b1;
      step();
      fence = 1'b0;
      check("prerst_count", 64'(count), 64'(2));
      check("prerst_fencing", 64'(enq_ready), 64'(0));
      reset_n = 1'b0;
      step();
      check("rst_fence_count", 64'(count), 64'(0));
      check("rst_fence_wr_mask", 64'(wr_mask), 64'(0));
      check("rst_fence_done", 64'(fence_done), 64'(0));
      check("rst_fence_ready", 64'(enq_ready), 64'(0));
      check("rst_fence_empty", 64'(empty), 64'(1));
      step();
      check("rst_fence_done_hold", 64'(fence_done), 64'(0));
      reset_n = 1'b1;
      #1;
      check("rst_release_ready", 64'(enq_ready), 64'(1));

      // Randomized traffic over a small address window so words collide often.
      for (int c = 0; c < 800; c++) begin
         enq_valid = ($urandom_range(0, 99) < 55);
         enq_addr  = 32'h800 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         enq_data  = 32'($urandom);
         enq_mask  = 4'($urandom_range(0, 15));
         wr_ready  = ($urandom_range(0, 99) < 40);
         ld_addr   = 32'h800 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
         fence     = ($urandom_range(0, 39) == 0);
         reset_n   = ($urandom_range(0, 199) != 0);
         step();
      end
      reset_n   = 1'b1;
      enq_valid = 1'b0;
      fence     = 1'b0;
      wr_ready  = 1'b1;
      repeat (DEPTH + 2) step();
      check("final_empty", 64'(empty), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
